// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding and baud divider.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Character stream from the receiver FIFO to its consumer.
// Handshake: a character transfers on every clock edge where o_valid and i_ready are
// both 1; o_char/o_valid are held stable while o_valid=1 and i_ready=0, and i_ready
// has no effect while o_valid=0.
interface uart_rx_fifo_if;
    logic [7:0] o_char;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_char, output o_valid, input i_ready);
    modport slave  (input o_char, input o_valid, output i_ready);
endinterface

// File: rtl/char_fifo.sv
// Show-ahead byte FIFO with extra-MSB pointers; a pop frees space for a same-cycle push.
module char_fifo #(
    parameter int AW = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);

    logic [7:0]  r_mem [0:(2**AW)-1];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    // Forced to zero when empty so the head reads 0 straight out of reset.
    assign o_dout = o_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a character FIFO; frame errors and overruns pulse for one cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 12000000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx,
    uart_rx_fifo_if.master   bus,
    output logic             o_overrun,
    output logic             o_frame_err,
    output logic [2:0]       o_state
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_overrun;
    logic          r_frame_err;

    logic          w_sample_stop;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_sample_stop = (r_state == STOP) && (r_cnt == CNT_LAST);
    assign w_push        = w_sample_stop && r_rx_s;
    assign w_pop         = bus.o_valid && bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_push && w_full && !w_pop;
            r_frame_err <= w_sample_stop && !r_rx_s;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) r_state <= START;
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        // A start bit that is gone by mid-bit was line noise.
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= r_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_idx == 3'd7) r_state <= STOP;
                        else               r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Held-low line must return high before another start bit counts.
                    r_cnt <= '0;
                    if (r_rx_s) r_state <= IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    char_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (r_shift),
        .i_pop   (w_pop),
        .o_dout  (bus.o_char),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign bus.o_valid  = !w_empty;
    assign o_overrun    = r_overrun;
    assign o_frame_err  = r_frame_err;
    assign o_state      = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven bit by bit, received bytes scored.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DIV = 104;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic       o_overrun;
    logic       o_frame_err;
    logic [2:0] o_state;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .CLK_HZ  (12000000),
        .BAUD    (115200),
        .FIFO_AW (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .bus         (bus),
        .o_overrun   (o_overrun),
        .o_frame_err (o_frame_err),
        .o_state     (o_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    int exp_ovr = 0;
    int exp_fe = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    // Monitor: records accepted characters and error pulses between clock edges.
    always @(negedge clk) begin
        if (!i_rst && bus.o_valid && bus.i_ready) rx_q.push_back(bus.o_char);
        if (o_overrun)   ovr_cnt++;
        if (o_frame_err) fe_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        i_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            tick(DIV);
        end
        i_rx = stop_bit;
        tick(DIV);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check({tag, "_byte"}, rx_q[i], exp_q[i]);
            else                 check({tag, "_byte"}, 32'hxxxx_xxxx, exp_q[i]);
        end
        check({tag, "_overrun"}, ovr_cnt, exp_ovr);
        check({tag, "_frame_err"}, fe_cnt, exp_fe);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        i_rst = 1'b1;
        i_rx = 1'b1;
        bus.i_ready = 1'b0;
        tick(5);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_char", bus.o_char, 8'h00);
        check("rst_overrun", o_overrun, 1'b0);
        check("rst_frame_err", o_frame_err, 1'b0);
        check("rst_state", o_state, IDLE);
        tick(20);

        // Single byte, consumer always ready
        bus.i_ready = 1'b1;
        send_byte(8'h41, 1'b1);
        tick(DIV);
        exp_q.push_back(8'h41);
        compare_q("single");

        // Fill FIFO, overrun on 17th byte, then drain
        bus.i_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h30 + 8'(i), 1'b1);
            tick(10);
        end
        @(negedge clk);
        check("full_valid", bus.o_valid, 1'b1);
        check("full_char", bus.o_char, 8'h30);
        send_byte(8'h40, 1'b1);
        tick(DIV);
        @(negedge clk);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_head_char", bus.o_char, 8'h30);
        exp_ovr = 1;
        bus.i_ready = 1'b1;
        tick(40);
        @(negedge clk);
        check("drain_valid", bus.o_valid, 1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h30 + 8'(i));
        compare_q("drain");

        // Frame error, then line held low
        send_byte(8'h55, 1'b0);
        tick(3000);
        @(negedge clk);
        check("break_state", o_state, BREAK);
        exp_fe = 1;
        compare_q("frame_err");
        i_rx = 1'b1;
        tick(2 * DIV);
        send_byte(8'h0A, 1'b1);
        tick(DIV);
        exp_q.push_back(8'h0A);
        compare_q("after_break");

        // Short low glitch on an idle line
        i_rx = 1'b0;
        tick(20);
        i_rx = 1'b1;
        tick(200);
        @(negedge clk);
        check("glitch_state", o_state, IDLE);
        compare_q("glitch");
        send_byte(8'h0C, 1'b1);
        tick(DIV);
        exp_q.push_back(8'h0C);
        compare_q("after_glitch");

        // Full FIFO with a pop landing exactly on the push cycle
        bus.i_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h60 + 8'(i), 1'b1);
            tick(10);
        end
        fork
            send_byte(8'h70, 1'b1);
            begin
                int waited;
                waited = 0;
                while (o_state != STOP && waited < 3000) begin
                    @(negedge clk);
                    waited++;
                end
                check("stop_reached", (o_state == STOP), 1'b1);
                tick(DIV - 1);
                bus.i_ready = 1'b1;
                tick(1);
                bus.i_ready = 1'b0;
                @(negedge clk);
                check("pushpop_valid", bus.o_valid, 1'b1);
                check("pushpop_char", bus.o_char, 8'h61);
            end
        join
        tick(DIV);
        bus.i_ready = 1'b1;
        tick(40);
        for (int i = 0; i < 17; i++) exp_q.push_back(8'h60 + 8'(i));
        compare_q("pushpop");

        // Reset mid-DATA with bytes queued
        bus.i_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        tick(20);
        i_rx = 1'b0;
        tick(DIV);
        i_rx = 1'b1;
        tick(DIV);
        i_rx = 1'b0;
        tick(DIV);
        i_rx = 1'b1;
        tick(50);
        @(negedge clk);
        check("pre_rst_state", o_state, DATA);
        check("pre_rst_valid", bus.o_valid, 1'b1);
        tick(1);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.o_valid, 1'b0);
        check("mid_rst_char", bus.o_char, 8'h00);
        check("mid_rst_state", o_state, IDLE);
        tick(12 * DIV);
        compare_q("mid_rst");
        bus.i_ready = 1'b1;
        send_byte(8'h7E, 1'b1);
        tick(DIV);
        exp_q.push_back(8'h7E);
        compare_q("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
